// File: rtl/game_round_ctrl.sv
// game_round_ctrl
// Sequences one dance round: IDLE -> PRESTART (3-2-1) -> PLAYING <-> PAUSED -> OVER.
// Owns the one-second prescaler, the round countdown and the beat divider that
// feeds the note spawner.
//
// Optional build macro: GAME_ROUND_HURRY_UP_EN
//   defined   : hurry flag in the last HURRY_SECS seconds, and double beat tempo
//               (the new beat period takes effect at the next beat wrap)
//   undefined : hurry tied low, beat period always BEAT_DIV
//
// Ports
//   CLOCK_50       in   system clock
//   reset          in   asynchronous, active-high reset
//   start_pulse    in   one-cycle start/restart request
//   pause_pulse    in   one-cycle pause/resume toggle
//   state          out  [2:0] IDLE=0 PRESTART=1 PLAYING=2 PAUSED=3 OVER=4
//   secs_left      out  [6:0] round seconds remaining
//   prestart_left  out  [1:0] pre-start seconds remaining
//   sec_tick       out  pulse coincident with each secs_left decrement
//   beat_tick      out  one-cycle beat pulse
//   play_active    out  high in PLAYING only
//   game_over      out  high in OVER only
//   hurry          out  hurry-up flag
module game_round_ctrl #(
  parameter int CLKS_PER_SEC  = 50000000,
  parameter int ROUND_SECS    = 60,
  parameter int PRESTART_SECS = 3,
  parameter int BEAT_DIV      = 25000000,
  parameter int HURRY_SECS    = 10
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       start_pulse,
  input  logic       pause_pulse,
  output logic [2:0] state,
  output logic [6:0] secs_left,
  output logic [1:0] prestart_left,
  output logic       sec_tick,
  output logic       beat_tick,
  output logic       play_active,
  output logic       game_over,
  output logic       hurry
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PRESTART = 3'd1,
    PLAYING  = 3'd2,
    PAUSED   = 3'd3,
    OVER     = 3'd4
  } state_t;

  localparam int PW = (CLKS_PER_SEC > 1) ? $clog2(CLKS_PER_SEC) : 1;
  localparam int BW = (BEAT_DIV > 1) ? $clog2(BEAT_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX  = PW'(CLKS_PER_SEC - 1);
  localparam logic [BW-1:0] BEAT_FULL  = BW'(BEAT_DIV - 1);
  localparam logic [6:0]    ROUND_LOAD = 7'(ROUND_SECS);
  localparam logic [1:0]    PRE_LOAD   = 2'(PRESTART_SECS);

  state_t        st_q, st_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [BW-1:0] beat_term;
  logic [6:0]    secs_d;
  logic [1:0]    pre_d;
  logic          sec_tick_d, beat_tick_d;
  logic          strobe;

  // Terminal count of the prescaler; only acted on in PRESTART/PLAYING,
  // since PAUSED may legitimately hold the counter at its terminal value.
  assign strobe = (presc_q == PRESC_MAX);
  assign state  = st_q;

  always_comb begin
    st_d        = st_q;
    presc_d     = presc_q;
    beat_d      = beat_q;
    secs_d      = secs_left;
    pre_d       = prestart_left;
    sec_tick_d  = 1'b0;
    beat_tick_d = 1'b0;
    case (st_q)
      IDLE: begin
        presc_d = '0;
        if (start_pulse) begin
          st_d   = PRESTART;
          pre_d  = PRE_LOAD;
          secs_d = ROUND_LOAD;
        end
      end
      PRESTART: begin
        presc_d = strobe ? '0 : presc_q + PW'(1);
        if (strobe) begin
          pre_d = prestart_left - 2'd1;
          if (prestart_left == 2'd1) begin
            st_d    = PLAYING;
            presc_d = '0;
            beat_d  = '0;
          end
        end
      end
      PLAYING: begin
        presc_d     = strobe ? '0 : presc_q + PW'(1);
        beat_d      = (beat_q == beat_term) ? '0 : beat_q + BW'(1);
        beat_tick_d = (beat_q == beat_term);
        if (pause_pulse) st_d = PAUSED;
        if (strobe) begin
          secs_d     = secs_left - 7'd1;
          sec_tick_d = 1'b1;
          // Final second: OVER overrides a coincident pause and the beat.
          if (secs_left == 7'd1) begin
            st_d        = OVER;
            beat_tick_d = 1'b0;
            presc_d     = '0;
          end
        end
      end
      PAUSED: begin
        if (pause_pulse) st_d = PLAYING;
      end
      OVER: begin
        presc_d = '0;
        if (start_pulse) begin
          st_d   = PRESTART;
          pre_d  = PRE_LOAD;
          secs_d = ROUND_LOAD;
        end
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      st_q          <= IDLE;
      presc_q       <= '0;
      beat_q        <= '0;
      secs_left     <= ROUND_LOAD;
      prestart_left <= 2'd0;
      sec_tick      <= 1'b0;
      beat_tick     <= 1'b0;
      play_active   <= 1'b0;
      game_over     <= 1'b0;
    end else begin
      st_q          <= st_d;
      presc_q       <= presc_d;
      beat_q        <= beat_d;
      secs_left     <= secs_d;
      prestart_left <= pre_d;
      sec_tick      <= sec_tick_d;
      beat_tick     <= beat_tick_d;
      play_active   <= (st_d == PLAYING);
      game_over     <= (st_d == OVER);
    end
  end

`ifdef GAME_ROUND_HURRY_UP_EN
  localparam logic [BW-1:0] BEAT_HALF = BW'(BEAT_DIV / 2 - 1);
  localparam logic [6:0]    HURRY_LIM = 7'(HURRY_SECS);

  logic [BW-1:0] beat_term_q, beat_term_d;
  logic          hurry_q, hurry_d;

  // The beat period is only re-chosen at a wrap so a beat is never cut short.
  always_comb begin
    beat_term_d = beat_term_q;
    if (st_q == PRESTART && st_d == PLAYING)
      beat_term_d = BEAT_FULL;
    else if (st_q == PLAYING && beat_q == beat_term_q)
      beat_term_d = hurry_q ? BEAT_HALF : BEAT_FULL;
    hurry_d = (st_d == PLAYING || st_d == PAUSED) &&
              (secs_d != 7'd0) && (secs_d <= HURRY_LIM);
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      beat_term_q <= BEAT_FULL;
      hurry_q     <= 1'b0;
    end else begin
      beat_term_q <= beat_term_d;
      hurry_q     <= hurry_d;
    end
  end

  assign beat_term = beat_term_q;
  assign hurry     = hurry_q;
`else
  assign beat_term = BEAT_FULL;
  assign hurry     = 1'b0;
`endif

endmodule

// File: tb/tb_game_round_ctrl.sv
// Bench for game_round_ctrl: a time-based behavioural model (elapsed clocks
// per phase, seconds and beats derived arithmetically) is compared on every
// falling edge, followed by directed scenarios with literal expectations and
// a randomized start/pause/reset phase.
module tb_game_round_ctrl;
  localparam int CLKS  = 10;
  localparam int ROUND = 5;
  localparam int PRE   = 3;
  localparam int BEAT  = 4;
  localparam int HURRY = 2;
`ifdef GAME_ROUND_HURRY_UP_EN
  localparam bit HURRY_ON = 1'b1;
`else
  localparam bit HURRY_ON = 1'b0;
`endif
  localparam int S_IDLE = 0, S_PRE = 1, S_PLAY = 2, S_PAUSE = 3, S_OVER = 4;

  logic       CLOCK_50 = 1'b0;
  logic       reset = 1'b1;
  logic       start_pulse = 1'b0;
  logic       pause_pulse = 1'b0;
  logic [2:0] state;
  logic [6:0] secs_left;
  logic [1:0] prestart_left;
  logic       sec_tick, beat_tick, play_active, game_over, hurry;

  int total = 0;
  int bad   = 0;

  always #5 CLOCK_50 = ~CLOCK_50;

  game_round_ctrl #(
    .CLKS_PER_SEC (CLKS),
    .ROUND_SECS   (ROUND),
    .PRESTART_SECS(PRE),
    .BEAT_DIV     (BEAT),
    .HURRY_SECS   (HURRY)
  ) dut (
    .CLOCK_50     (CLOCK_50),
    .reset        (reset),
    .start_pulse  (start_pulse),
    .pause_pulse  (pause_pulse),
    .state        (state),
    .secs_left    (secs_left),
    .prestart_left(prestart_left),
    .sec_tick     (sec_tick),
    .beat_tick    (beat_tick),
    .play_active  (play_active),
    .game_over    (game_over),
    .hurry        (hurry)
  );

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_phase     = S_IDLE;
  int m_pre_clk   = 0;   // clocks spent in PRESTART
  int m_run_clk   = 0;   // clocks spent actually playing this round
  int m_next_beat = BEAT;
  bit m_sec_tick  = 1'b0;
  bit m_beat_tick = 1'b0;

  function automatic int exp_prestart();
    return (m_phase == S_PRE) ? PRE - m_pre_clk / CLKS : 0;
  endfunction

  function automatic int exp_secs();
    if (m_phase == S_IDLE || m_phase == S_PRE) return ROUND;
    return ROUND - m_run_clk / CLKS;
  endfunction

  function automatic int exp_hurry();
    int s;
    s = exp_secs();
    return (HURRY_ON && (m_phase == S_PLAY || m_phase == S_PAUSE) && s > 0 && s <= HURRY) ? 1 : 0;
  endfunction

  task automatic model_reset();
    m_phase = S_IDLE; m_pre_clk = 0; m_run_clk = 0; m_next_beat = BEAT;
    m_sec_tick = 1'b0; m_beat_tick = 1'b0;
  endtask

  task automatic model_step(input bit st, input bit pa);
    int hurry_before;
    m_sec_tick  = 1'b0;
    m_beat_tick = 1'b0;
    case (m_phase)
      S_IDLE, S_OVER: if (st) begin
        m_phase = S_PRE; m_pre_clk = 0; m_run_clk = 0;
      end
      S_PRE: begin
        m_pre_clk++;
        if (m_pre_clk == PRE * CLKS) begin
          m_phase = S_PLAY; m_run_clk = 0; m_next_beat = BEAT;
        end
      end
      S_PLAY: begin
        hurry_before = exp_hurry();
        m_run_clk++;
        if (m_run_clk % CLKS == 0) m_sec_tick = 1'b1;
        if (m_run_clk == ROUND * CLKS) m_phase = S_OVER;
        else begin
          if (m_run_clk == m_next_beat) begin
            m_beat_tick = 1'b1;
            m_next_beat += (hurry_before != 0) ? BEAT / 2 : BEAT;
          end
          if (pa) m_phase = S_PAUSE;
        end
      end
      S_PAUSE: if (pa) m_phase = S_PLAY;
      default: m_phase = S_IDLE;
    endcase
  endtask

  initial forever begin
    @(posedge CLOCK_50 or posedge reset);
    if (reset) model_reset();
    else model_step(start_pulse, pause_pulse);
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge CLOCK_50);
    check("m_state",     int'(state),         m_phase);
    check("m_secs_left", int'(secs_left),     exp_secs());
    check("m_prestart",  int'(prestart_left), exp_prestart());
    check("m_sec_tick",  int'(sec_tick),      int'(m_sec_tick));
    check("m_beat_tick", int'(beat_tick),     int'(m_beat_tick));
    check("m_play",      int'(play_active),   (m_phase == S_PLAY) ? 1 : 0);
    check("m_over",      int'(game_over),     (m_phase == S_OVER) ? 1 : 0);
    check("m_hurry",     int'(hurry),         exp_hurry());
  end

  task automatic pulse_start();
    start_pulse = 1'b1;
    @(negedge CLOCK_50);
    start_pulse = 1'b0;
  endtask

  task automatic pulse_pause();
    pause_pulse = 1'b1;
    @(negedge CLOCK_50);
    pause_pulse = 1'b0;
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    int ns, nb, nh, changes, k;
    bit found;
    logic [14:0] snap;

    repeat (3) @(negedge CLOCK_50);
    reset = 1'b0;
    check("rst_state", int'(state), 0);
    check("rst_secs", int'(secs_left), 5);
    check("rst_pre", int'(prestart_left), 0);
    check("rst_over", int'(game_over), 0);

    // start -> 3-2-1 countdown -> PLAYING
    @(negedge CLOCK_50);
    pulse_start();
    check("pre_state", int'(state), 1);
    check("pre_load", int'(prestart_left), 3);
    check("pre_secs", int'(secs_left), 5);
    repeat (10) @(negedge CLOCK_50);
    check("pre_2", int'(prestart_left), 2);
    repeat (10) @(negedge CLOCK_50);
    check("pre_1", int'(prestart_left), 1);
    repeat (10) @(negedge CLOCK_50);
    check("play_state", int'(state), 2);
    check("play_secs", int'(secs_left), 5);
    check("play_pre0", int'(prestart_left), 0);

    // uninterrupted round
    ns = 0; nb = 0; nh = 0;
    repeat (50) begin
      @(negedge CLOCK_50);
      ns += int'(sec_tick); nb += int'(beat_tick); nh += int'(hurry);
    end
    check("end_state", int'(state), 4);
    check("end_over", int'(game_over), 1);
    check("end_secs", int'(secs_left), 0);
    check("end_tick", int'(sec_tick), 1);
    check("sec_ticks", ns, 5);
    check("beat_ticks", nb, HURRY_ON ? 16 : 12);
    check("hurry_cycles", nh, HURRY_ON ? 20 : 0);
    @(negedge CLOCK_50);
    snap = {state, secs_left, prestart_left, play_active, game_over, hurry};
    changes = 0;
    repeat (100) begin
      @(negedge CLOCK_50);
      if ({state, secs_left, prestart_left, play_active, game_over, hurry} != snap ||
          sec_tick || beat_tick) changes++;
    end
    check("over_static", changes, 0);

    // restart from OVER
    pulse_start();
    check("restart_state", int'(state), 1);
    check("restart_secs", int'(secs_left), 5);
    check("restart_over", int'(game_over), 0);
    check("restart_pre", int'(prestart_left), 3);
    repeat (30) @(negedge CLOCK_50);
    check("replay_state", int'(state), 2);

    // pause 3 clocks into a second, hold, resume
    repeat (2) @(negedge CLOCK_50);
    pulse_pause();
    check("paused_state", int'(state), 3);
    ns = 0;
    repeat (100) begin
      @(negedge CLOCK_50);
      ns += int'(sec_tick) + int'(beat_tick);
    end
    check("paused_ticks", ns, 0);
    check("paused_secs", int'(secs_left), 5);
    pulse_pause();
    check("resumed_state", int'(state), 2);
    k = 0; found = 1'b0;
    while (!found && k < 20) begin
      @(negedge CLOCK_50);
      k++;
      if (sec_tick) found = 1'b1;
    end
    check("resume_latency", k, 7);
    check("resume_secs", int'(secs_left), 4);

    // pause coincident with the final strobe
    repeat (39) @(negedge CLOCK_50);
    pulse_pause();
    check("final_pause_state", int'(state), 4);
    check("final_pause_over", int'(game_over), 1);
    check("final_pause_secs", int'(secs_left), 0);
    repeat (5) @(negedge CLOCK_50);
    check("final_pause_hold", int'(state), 4);

    // asynchronous reset during PLAYING
    pulse_start();
    repeat (42) @(negedge CLOCK_50);
    check("pre_reset_state", int'(state), 2);
    @(posedge CLOCK_50);
    #2 reset = 1'b1;
    #1;
    check("arst_state", int'(state), 0);
    check("arst_secs", int'(secs_left), 5);
    check("arst_pre", int'(prestart_left), 0);
    check("arst_sec_tick", int'(sec_tick), 0);
    check("arst_beat_tick", int'(beat_tick), 0);
    check("arst_play", int'(play_active), 0);
    check("arst_over", int'(game_over), 0);
    check("arst_hurry", int'(hurry), 0);
    @(negedge CLOCK_50);
    reset = 1'b0;

    // randomized phase
    repeat (4000) begin
      @(negedge CLOCK_50);
      start_pulse = ($urandom_range(0, 99) < 3);
      pause_pulse = ($urandom_range(0, 99) < 6);
      if ($urandom_range(0, 599) == 0) begin
        #1 reset = 1'b1;
        #2 reset = 1'b0;
      end
    end
    @(negedge CLOCK_50);
    start_pulse = 1'b0;
    pause_pulse = 1'b0;
    repeat (5) @(negedge CLOCK_50);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/game_round_ctrl.md
Name: game_round_ctrl

Overview:
- Sequences one dance round: start, 3-2-1 pre-start countdown, timed play, pause/resume, game over.
- Owns the 1-second prescaler and round countdown, so seconds and game-over no longer come from a free-running timer.
- Emits a beat strobe for the note spawner.
- Sits between the debounced button logic and the HEX display/scoring logic.

Parameters:
- CLKS_PER_SEC, 50000000, clock cycles per second tick (exact period, no +1).
- ROUND_SECS, 60, round length in seconds; must be 1..99.
- PRESTART_SECS, 3, pre-start countdown seconds; must be 1..3.
- BEAT_DIV, 25000000, clock cycles per beat_tick.
- HURRY_SECS, 10, hurry threshold in seconds; used only with HURRY_UP_EN.

Ports:
- CLOCK_50  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start_pulse  in  1  one-cycle start/restart request.
- pause_pulse  in  1  one-cycle pause/resume toggle.
- state  out  3  current state encoding.
- secs_left  out  7  round seconds remaining.
- prestart_left  out  2  pre-start seconds remaining.
- sec_tick  out  1  one-cycle pulse, coincident with each secs_left decrement.
- beat_tick  out  1  one-cycle beat pulse.
- play_active  out  1  high in PLAYING only.
- game_over  out  1  high in OVER only.
- hurry  out  1  hurry-up flag.

Behaviour:
- Single clock CLOCK_50; reset is asynchronous and active-high. All outputs are registered.
- Reset values: state=IDLE, secs_left=ROUND_SECS, prestart_left=0, sec_tick=0, beat_tick=0, play_active=0, game_over=0, hurry=0, prescaler=0, beat counter=0.
- State encoding: IDLE=0, PRESTART=1, PLAYING=2, PAUSED=3, OVER=4.
- Prescaler (width $clog2(CLKS_PER_SEC)):
  - Counts 0..CLKS_PER_SEC-1; the internal strobe fires on the cycle count==CLKS_PER_SEC-1, then wraps to 0.
  - Runs in PRESTART and PLAYING; holds its value in PAUSED; cleared in IDLE/OVER and on entry to PRESTART or PLAYING (not on resume).
- Input latency: a pulse sampled at edge N takes effect in the registered outputs after edge N.
- IDLE:
  - start_pulse -> PRESTART, prestart_left=PRESTART_SECS, secs_left=ROUND_SECS.
  - pause_pulse ignored; start wins if both arrive together.
- PRESTART:
  - Each strobe decrements prestart_left.
  - Strobe with prestart_left==1 -> PLAYING, prestart_left=0.
  - start_pulse and pause_pulse ignored.
- PLAYING:
  - Each strobe decrements secs_left; sec_tick=1 in the same cycle the new value appears.
  - Strobe with secs_left==1 -> secs_left=0, OVER, game_over=1. There is no extra second displayed at 0.
  - pause_pulse -> PAUSED.
  - Strobe and pause in the same cycle: decrement is taken, then PAUSED; if that decrement reaches 0, OVER wins and pause is dropped.
  - start_pulse ignored.
- PAUSED:
  - Prescaler, beat counter and secs_left are frozen; no ticks.
  - pause_pulse -> PLAYING, counters resume from held values.
  - start_pulse ignored.
- OVER:
  - Outputs hold.
  - start_pulse -> PRESTART with full reload; game_over clears on the same edge.
- Beat counter:
  - Counts 0..BEAT_DIV-1 in PLAYING only; beat_tick pulses on wrap.
  - Held in PAUSED; cleared on PLAYING entry from PRESTART.
  - No beat_tick on the cycle PLAYING is left for OVER.
- Reset mid-operation: immediate, without a clock edge, return to the reset values, from any state.

Optional Feature:
- Macro: GAME_ROUND_HURRY_UP_EN.
- Defined:
  - In PLAYING/PAUSED with secs_left<=HURRY_SECS and secs_left>0, hurry=1.
  - Beat terminal count becomes BEAT_DIV/2-1 (double tempo); the switch applies at the next beat wrap.
  - hurry=0 in all other states.
- Undefined: hurry tied 0; beat period is always BEAT_DIV.

Test Plan:
Bench parameters: CLKS_PER_SEC=10, ROUND_SECS=5, PRESTART_SECS=3, BEAT_DIV=4.
1. Reset, then start_pulse -> state=1, prestart_left=3, which steps 2, 1; 30 clocks after entry, state=2, secs_left=5.
2. Uninterrupted PLAYING -> secs_left 4,3,2,1,0 at 10-clock spacing with 5 sec_tick pulses; state=4 and game_over=1 with the final tick; 12 beat_tick pulses; outputs static for 100 further clocks.
3. pause_pulse 3 clocks into a second, hold 100 clocks -> secs_left unchanged, no ticks; resume -> next decrement exactly 7 clocks later.
4. pause_pulse coincident with the final strobe -> state=4, game_over=1, no PAUSED.
5. reset asserted between clock edges during PLAYING -> all outputs at reset values before the next edge; start_pulse in OVER -> PRESTART, secs_left=5, game_over=0.
6. With GAME_ROUND_HURRY_UP_EN and HURRY_SECS=2 -> hurry rises when secs_left=2, beat spacing becomes 2 clocks, hurry=0 in OVER; without the macro, hurry stays 0 throughout.
